srcbuf_row_loader: RTL
======================

// Module: srcbuf_row_loader
// PURPOSE
//  Upstream feeder for the sourcebuffer dual-port RAM (1024 rows x 128 x 32-bit). Accepts a valid/ready
//  stream of 512-bit feature beats, packs 8 beats into one 4096-bit row, and drives sourcebuffer write
//  port A (data_a / write_address_a / wren_a). Loads num_rows consecutive rows from base_addr per start.
// PARAMETERS
//  WL      32    bits per feature element
//  NUM     128   elements per buffer row (ROW_W = WL*NUM = 4096)
//  BEAT_W  512   input beat width; BEATS = ROW_W/BEAT_W = 8; ROW_W must be a multiple of BEAT_W
//  ADDR_W  10    buffer address width (depth 2**ADDR_W = 1024)
// PORTS
//  clk        in   1       clock, all logic rising-edge
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       begin load; sampled only in IDLE
//  base_addr  in   ADDR_W  first row address; captured on accepted start
//  num_rows   in   ADDR_W+1  rows to load (0..1024); captured on accepted start
//  in_data    in   BEAT_W  feature beat
//  in_valid   in   1       beat valid
//  in_ready   out  1       beat accept; transfer when in_valid & in_ready
//  wr_data    out  ROW_W   -> sourcebuffer data_a
//  wr_addr    out  ADDR_W  -> sourcebuffer write_address_a
//  wr_en      out  1       -> sourcebuffer wren_a; one-cycle pulse per row
//  busy       out  1       high in LOAD and DONE
//  done       out  1       one-cycle pulse at end of job
// BEHAVIOUR
//  - Reset: state IDLE; in_ready, wr_en, busy, done = 0; wr_data, wr_addr, beat/row counters = 0;
//    partial row discarded. Reset mid-job aborts with no further writes.
//  - FSM IDLE -> LOAD on start & num_rows != 0; IDLE -> DONE on start & num_rows == 0;
//    LOAD -> DONE when the last beat of the last row is accepted; DONE -> IDLE unconditionally.
//  - start while busy is ignored (no re-capture).
//  - in_ready = 1 exactly in LOAD; no back-pressure needed, full 1 beat/cycle throughput.
//  - Packing: k-th accepted beat of a row (k = 0..7) lands in row[k*BEAT_W +: BEAT_W]; beat 0 holds
//    elements 0..15 (little-endian). Gaps in in_valid hold beat count; no timeout.
//  - Write latency: row completed by beat accepted at edge T -> wr_en = 1 in cycle T+1 with
//    wr_data = full row, wr_addr = (base_addr + row_idx) mod 2**ADDR_W (wraps 1023 -> 0).
//    Assembly register is separate from wr_data, so beat 0 of the next row can be accepted in T+1.
//  - wr_data/wr_addr hold their last value when wr_en = 0.
//  - done: pulses in the DONE cycle; for non-empty jobs coincides with the final wr_en.
//    busy falls the following cycle. num_rows = 0: done one cycle after start, wr_en never asserts.
//  - num_rows = 1024 with any base writes every address exactly once.
// CONFIGURATION
//  SRCBUF_LOADER_PERF_EN defined: extra port perf_stall out 32: counts LOAD cycles with in_valid = 0;
//    cleared on accepted start and reset, saturates at 2**32-1, holds after job end.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - srcbuf_pkg: WL, NUM, ROW_W, BEAT_W, BEATS_PER_ROW, ADDR_W constants; typedef enum
//    {IDLE, LOAD, DONE} ld_state_t; row_t = logic [ROW_W-1:0].
//  - Sub-module srcbuf_row_packer: beat counter + assembly register; emits row_valid / row pulse
//    on the 8th beat. Top level holds FSM, row counter, address generation, output registers.
// TESTING (bench instantiates loader driving a real sourcebuffer, reads back via port B)
//  1. Assert rst mid-cycle, no clock edge -> all outputs 0 immediately; release, idle 5 cycles -> no wr_en.
//  2. base=5, num_rows=1, beats 0..7 = {16{32'(k)}} back-to-back -> single wr_en cycle after beat 7,
//     wr_addr=5, elements 16k..16k+15 = k; done same cycle; readback of row 5 matches.
//  3. base=100, num_rows=3, in_valid toggled 1/0 -> 3 wr_en at addrs 100,101,102, exactly one done,
//     24 beats accepted, busy low the cycle after done.
//  4. base=1023, num_rows=2 -> writes at 1023 then 0; row 1022 and row 1 unchanged.
//  5. num_rows=0 -> done one cycle after start, wr_en never high; start during busy -> ignored.
//  6. rst after beat 4 of row 0, then start base=7, num_rows=1 with fresh beats -> row 7 has only new
//     data; no write to the aborted address. PERF_EN build: 3-cycle in_valid gap -> perf_stall = 3.

Source files
------------

// File: rtl/srcbuf_pkg.sv
// Shared constants and types for the sourcebuffer row loader: geometry of one
// buffer row, input beat width and the loader state encoding.
package srcbuf_pkg;

    localparam int WL            = 32;
    localparam int NUM           = 128;
    localparam int ROW_W         = WL * NUM;
    localparam int BEAT_W        = 512;
    localparam int BEATS_PER_ROW = ROW_W / BEAT_W;
    localparam int ADDR_W        = 10;
    localparam int BEAT_CNT_W    = $clog2(BEATS_PER_ROW);
    localparam int PERF_W        = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } ld_state_t;

    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [BEAT_W-1:0] beat_t;

endpackage

// File: rtl/srcbuf_row_packer.sv
// Packs BEATS_PER_ROW accepted beats into one row, little-endian (beat 0 in the
// low slice). Raises row_vld combinationally while the final beat is accepted.
module srcbuf_row_packer
    import srcbuf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              beat_vld,
    input  logic [BEAT_W-1:0] beat_data,
    output logic              row_vld,
    output logic [ROW_W-1:0]  row_data
);

    localparam int ASM_W = ROW_W - BEAT_W;
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS_PER_ROW - 1);

    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [ASM_W-1:0]      asm_q;

    // The top slice is never stored: the final beat is forwarded straight into
    // row_data, so the assembly register is free for the next row one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            asm_q    <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (beat_vld) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            for (int k = 0; k < BEATS_PER_ROW - 1; k++) begin
                if (beat_cnt == BEAT_CNT_W'(k))
                    asm_q[k*BEAT_W +: BEAT_W] <= beat_data;
            end
        end
    end

    assign row_vld  = beat_vld && (beat_cnt == LAST_BEAT);
    assign row_data = {beat_data, asm_q};

endmodule

// File: rtl/srcbuf_row_loader.sv
// Streams 512-bit beats into full 4096-bit rows and writes them to sourcebuffer
// port A. Optional SRCBUF_LOADER_PERF_EN adds a perf_stall input-starvation counter.
module srcbuf_row_loader
    import srcbuf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_rows,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ROW_W-1:0]  wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic              busy,
`ifdef SRCBUF_LOADER_PERF_EN
    output logic [PERF_W-1:0] perf_stall,
`endif
    output logic              done
);

    ld_state_t         state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   num_q;
    logic [ADDR_W:0]   row_idx;
    logic              beat_acc;
    logic              job_start;
    logic              last_row;
    logic              row_vld;
    logic [ROW_W-1:0]  row_data;

    assign beat_acc  = in_valid && in_ready;
    assign job_start = (state == IDLE) && start;
    assign last_row  = (row_idx == num_q - 1'b1);

    srcbuf_row_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (job_start),
        .beat_vld  (beat_acc),
        .beat_data (in_data),
        .row_vld   (row_vld),
        .row_data  (row_data)
    );

    // Control FSM plus the registered write port; addresses wrap modulo 2**ADDR_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            base_q   <= '0;
            num_q    <= '0;
            row_idx  <= '0;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_data  <= '0;
            wr_addr  <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        num_q   <= num_rows;
                        row_idx <= '0;
                        busy    <= 1'b1;
                        if (num_rows != '0) begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (row_vld) begin
                        wr_en   <= 1'b1;
                        wr_data <= row_data;
                        wr_addr <= base_q + row_idx[ADDR_W-1:0];
                        row_idx <= row_idx + 1'b1;
                        if (last_row) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef SRCBUF_LOADER_PERF_EN
    // Counts LOAD cycles starved of input; saturates rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_stall <= '0;
        else if (job_start)
            perf_stall <= '0;
        else if ((state == LOAD) && !in_valid && (perf_stall != '1))
            perf_stall <= perf_stall + 1'b1;
    end
`endif

endmodule
